// File: rtl/hsem_core.sv
// hsem_core: hardware semaphore register bank and lock engine.
//
// Sits behind the HSEM AHB bus interface unit and consumes its registered
// access strobes. Each semaphore has a LOCK bit, an owning core ID and a
// process ID. A semaphore can be taken in two steps (write with bit31 set)
// or in one step (read of its RLR alias). The owner frees it by writing
// bit31=0 together with a matching PROCID. A keyed CR write frees every
// semaphore held by one core. Each free event sets an ISR bit; sem_irq is
// the OR of ISR & IER.
//
// Register map (byte addresses, reg_addr[1:0] ignored):
//   0x00+4*i R[i]    bit31 LOCK, [15:8] COREID, [7:0] PROCID
//   0x40+4*i RLR[i]  read-lock alias of R[i]
//   0x80 IER  RW     0x84 ICR  W1C of ISR, reads 0
//   0x88 ISR  RO     0x8C MISR ISR & IER
//   0x90 CR   WO     [31:16] key, [15:8] core whose locks are cleared
//
// Ports:
//   hclk       clock, all state changes on the rising edge
//   hreset     synchronous active-high reset
//   wr_en      write strobe, one cycle per access
//   rd_en      read strobe, one cycle per access
//   reg_addr   byte address of the access
//   ihwdata    write data
//   master_id  ID of the requesting core
//   ihrdata    read data, combinational from reg_addr / state / master_id
//   sem_irq    registered |(ISR & IER)
//   sem_lock   registered LOCK bit of every semaphore
//
// AHB_DATA_WIDTH must be at least 32 and AHB_SEM_ADDR_WIDTH at least 8.

module hsem_core #(
    parameter int          NUM_SEM            = 8,
    parameter int          AHB_DATA_WIDTH     = 32,
    parameter int          AHB_SEM_ADDR_WIDTH = 8,
    parameter logic [15:0] CLR_KEY            = 16'h5A5A
) (
    input  logic                          hclk,
    input  logic                          hreset,
    input  logic                          wr_en,
    input  logic                          rd_en,
    input  logic [AHB_SEM_ADDR_WIDTH-1:0] reg_addr,
    input  logic [AHB_DATA_WIDTH-1:0]     ihwdata,
    input  logic [7:0]                    master_id,
    output logic [AHB_DATA_WIDTH-1:0]     ihrdata,
    output logic                          sem_irq,
    output logic [NUM_SEM-1:0]            sem_lock
);

    localparam int WW = AHB_SEM_ADDR_WIDTH - 2;
    localparam int HW = AHB_SEM_ADDR_WIDTH - 6;

    localparam logic [WW-1:0] A_IER  = WW'(32'h20);
    localparam logic [WW-1:0] A_ICR  = WW'(32'h21);
    localparam logic [WW-1:0] A_ISR  = WW'(32'h22);
    localparam logic [WW-1:0] A_MISR = WW'(32'h23);
    localparam logic [WW-1:0] A_CR   = WW'(32'h24);

    // Semaphore and interrupt state
    logic [NUM_SEM-1:0] lock_q;
    logic [7:0]         coreid_q [NUM_SEM];
    logic [7:0]         procid_q [NUM_SEM];
    logic [NUM_SEM-1:0] ier_q;
    logic [NUM_SEM-1:0] isr_q;

    // Next-state values
    logic [NUM_SEM-1:0] lock_n;
    logic [7:0]         coreid_n [NUM_SEM];
    logic [7:0]         procid_n [NUM_SEM];
    logic [NUM_SEM-1:0] ier_n;
    logic [NUM_SEM-1:0] isr_n;
    logic [NUM_SEM-1:0] isr_set;
    logic [NUM_SEM-1:0] isr_clr;

    // Address decode
    logic [WW-1:0]      addr_word;
    logic [3:0]         sem_idx;
    logic               in_r_region;
    logic               in_rlr_region;
    logic [NUM_SEM-1:0] hit_r;
    logic [NUM_SEM-1:0] hit_rlr;
    logic               key_ok;
    logic               unused_addr_lsb;

    assign addr_word       = reg_addr[AHB_SEM_ADDR_WIDTH-1:2];
    assign sem_idx         = reg_addr[5:2];
    assign in_r_region     = (reg_addr[AHB_SEM_ADDR_WIDTH-1:6] == '0);
    assign in_rlr_region   = (reg_addr[AHB_SEM_ADDR_WIDTH-1:6] == HW'(1));
    assign key_ok          = (ihwdata[31:16] == CLR_KEY);
    assign unused_addr_lsb = ^reg_addr[1:0];

    // Indices at or beyond NUM_SEM match no semaphore, so those slots read 0
    // and ignore writes without any extra range check.
    always_comb begin
        hit_r   = '0;
        hit_rlr = '0;
        for (int i = 0; i < NUM_SEM; i++) begin
            hit_r[i]   = in_r_region   && (sem_idx == 4'(i));
            hit_rlr[i] = in_rlr_region && (sem_idx == 4'(i));
        end
    end

    // Read mux. A free semaphore read through RLR shows the value it is
    // about to take, so the reader learns it won the lock in the same access.
    always_comb begin
        ihrdata = '0;
        for (int i = 0; i < NUM_SEM; i++) begin
            if (hit_r[i]) begin
                ihrdata[31:0] = {lock_q[i], 15'b0, coreid_q[i], procid_q[i]};
            end
            if (hit_rlr[i]) begin
                if (lock_q[i]) begin
                    ihrdata[31:0] = {1'b1, 15'b0, coreid_q[i], procid_q[i]};
                end else begin
                    ihrdata[31:0] = {1'b1, 15'b0, master_id, 8'h00};
                end
            end
        end
        if (addr_word == A_IER) begin
            ihrdata[NUM_SEM-1:0] = ier_q;
        end else if (addr_word == A_ISR) begin
            ihrdata[NUM_SEM-1:0] = isr_q;
        end else if (addr_word == A_MISR) begin
            ihrdata[NUM_SEM-1:0] = isr_q & ier_q;
        end
    end

    // Lock engine. A write always wins over a simultaneous read, so the
    // RLR side effect only applies on a pure read.
    always_comb begin
        lock_n   = lock_q;
        coreid_n = coreid_q;
        procid_n = procid_q;
        ier_n    = ier_q;
        isr_set  = '0;
        isr_clr  = '0;

        if (wr_en) begin
            for (int i = 0; i < NUM_SEM; i++) begin
                if (hit_r[i]) begin
                    if (ihwdata[31]) begin
                        if (!lock_q[i]) begin
                            lock_n[i]   = 1'b1;
                            coreid_n[i] = master_id;
                            procid_n[i] = ihwdata[7:0];
                        end
                    end else if (lock_q[i] && coreid_q[i] == master_id
                                 && procid_q[i] == ihwdata[7:0]) begin
                        lock_n[i]   = 1'b0;
                        coreid_n[i] = 8'h00;
                        procid_n[i] = 8'h00;
                        isr_set[i]  = 1'b1;
                    end
                end
            end

            if (addr_word == A_IER) begin
                ier_n = ihwdata[NUM_SEM-1:0];
            end

            if (addr_word == A_ICR) begin
                isr_clr = ihwdata[NUM_SEM-1:0];
            end

            if (addr_word == A_CR && key_ok) begin
                for (int i = 0; i < NUM_SEM; i++) begin
                    if (lock_q[i] && coreid_q[i] == ihwdata[15:8]) begin
                        lock_n[i]   = 1'b0;
                        coreid_n[i] = 8'h00;
                        procid_n[i] = 8'h00;
                        isr_set[i]  = 1'b1;
                    end
                end
            end
        end else if (rd_en) begin
            for (int i = 0; i < NUM_SEM; i++) begin
                if (hit_rlr[i] && !lock_q[i]) begin
                    lock_n[i]   = 1'b1;
                    coreid_n[i] = master_id;
                    procid_n[i] = 8'h00;
                end
            end
        end

        // A free event beats an ICR clear of the same bit.
        isr_n = (isr_q & ~isr_clr) | isr_set;
    end

    // State registers. sem_irq is taken from next-state values so it moves
    // on the same edge as ISR/IER.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            lock_q  <= '0;
            ier_q   <= '0;
            isr_q   <= '0;
            sem_irq <= 1'b0;
            for (int i = 0; i < NUM_SEM; i++) begin
                coreid_q[i] <= 8'h00;
                procid_q[i] <= 8'h00;
            end
        end else begin
            lock_q   <= lock_n;
            coreid_q <= coreid_n;
            procid_q <= procid_n;
            ier_q    <= ier_n;
            isr_q    <= isr_n;
            sem_irq  <= |(isr_n & ier_n);
        end
    end

    assign sem_lock = lock_q;

endmodule

// File: tb/tb_hsem_core.sv
// tb_hsem_core: directed self-checking bench for hsem_core.
//
// Inputs change on the falling edge and outputs are sampled 1 ns later,
// well away from the rising edge where the DUT updates.

module tb_hsem_core;

    logic        hclk;
    logic        hreset;
    logic        wr_en;
    logic        rd_en;
    logic [7:0]  reg_addr;
    logic [31:0] ihwdata;
    logic [7:0]  master_id;
    logic [31:0] ihrdata;
    logic        sem_irq;
    logic [7:0]  sem_lock;

    int tests_run;
    int tests_failed;

    hsem_core #(
        .NUM_SEM            (8),
        .AHB_DATA_WIDTH     (32),
        .AHB_SEM_ADDR_WIDTH (8),
        .CLR_KEY            (16'h5A5A)
    ) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .reg_addr  (reg_addr),
        .ihwdata   (ihwdata),
        .master_id (master_id),
        .ihrdata   (ihrdata),
        .sem_irq   (sem_irq),
        .sem_lock  (sem_lock)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // One bus access: strobes held for exactly one rising edge. The read
    // data is sampled before that edge, as the BIU would capture it.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [7:0] addr,
                                 input logic [31:0] data, input logic [7:0] mid,
                                 output logic [31:0] rdata);
        @(negedge hclk);
        wr_en     = wr;
        rd_en     = rd;
        reg_addr  = addr;
        ihwdata   = data;
        master_id = mid;
        #1 rdata  = ihrdata;
        @(negedge hclk);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    // Look at a register through the combinational read path without strobes.
    task automatic peek(input logic [7:0] addr, output logic [31:0] rdata);
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        reg_addr = addr;
        #1 rdata = ihrdata;
    endtask

    initial begin
        logic [31:0] rd;

        tests_run    = 0;
        tests_failed = 0;
        hreset    = 1'b1;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        reg_addr  = 8'h00;
        ihwdata   = 32'h0;
        master_id = 8'h00;
        repeat (3) @(negedge hclk);
        hreset = 1'b0;

        // Reset state
        peek(8'h00, rd); checkOutput("reset_R0", rd, 32'h0);
        peek(8'h80, rd); checkOutput("reset_IER", rd, 32'h0);
        peek(8'h88, rd); checkOutput("reset_ISR", rd, 32'h0);
        checkOutput("reset_irq", {31'b0, sem_irq}, 32'h0);
        checkOutput("reset_lock", {24'b0, sem_lock}, 32'h0);

        // 2-step lock by core 1, second locker rejected
        applyStimulus(1, 0, 8'h00, 32'h8000_0007, 8'h01, rd);
        peek(8'h00, rd); checkOutput("lock_R0", rd, 32'h8000_0107);
        checkOutput("lock_R0_bit", {24'b0, sem_lock}, 32'h01);
        applyStimulus(1, 0, 8'h00, 32'h8000_0003, 8'h02, rd);
        peek(8'h00, rd); checkOutput("relock_other", rd, 32'h8000_0107);
        applyStimulus(1, 0, 8'h00, 32'h8000_0009, 8'h01, rd);
        peek(8'h00, rd); checkOutput("relock_same", rd, 32'h8000_0107);

        // Unlock attempts: wrong PROCID, wrong core, then correct owner
        applyStimulus(1, 0, 8'h80, 32'h0000_0001, 8'h01, rd);
        peek(8'h80, rd); checkOutput("ier_rw", rd, 32'h01);
        applyStimulus(1, 0, 8'h00, 32'h0000_0005, 8'h01, rd);
        peek(8'h00, rd); checkOutput("unlock_bad_proc", rd, 32'h8000_0107);
        applyStimulus(1, 0, 8'h00, 32'h0000_0007, 8'h02, rd);
        peek(8'h00, rd); checkOutput("unlock_bad_core", rd, 32'h8000_0107);
        checkOutput("no_irq_yet", {31'b0, sem_irq}, 32'h0);
        applyStimulus(1, 0, 8'h00, 32'h0000_0007, 8'h01, rd);
        peek(8'h00, rd); checkOutput("unlock_R0", rd, 32'h0);
        peek(8'h88, rd); checkOutput("unlock_ISR", rd, 32'h01);
        peek(8'h8C, rd); checkOutput("unlock_MISR", rd, 32'h01);
        checkOutput("unlock_irq", {31'b0, sem_irq}, 32'h1);
        checkOutput("unlock_lock", {24'b0, sem_lock}, 32'h0);

        // Unlocking a free semaphore is not an event
        applyStimulus(1, 0, 8'h84, 32'h0000_0001, 8'h00, rd);
        peek(8'h88, rd); checkOutput("icr_clear", rd, 32'h0);
        checkOutput("icr_irq", {31'b0, sem_irq}, 32'h0);
        applyStimulus(1, 0, 8'h00, 32'h0000_0000, 8'h00, rd);
        peek(8'h88, rd); checkOutput("free_unlock_isr", rd, 32'h0);
        peek(8'h84, rd); checkOutput("icr_reads0", rd, 32'h0);

        // 1-step lock via RLR[2]
        applyStimulus(0, 1, 8'h48, 32'h0, 8'h03, rd);
        checkOutput("rlr_first", rd, 32'h8000_0300);
        peek(8'h08, rd); checkOutput("rlr_R2", rd, 32'h8000_0300);
        checkOutput("rlr_lock", {24'b0, sem_lock}, 32'h04);
        applyStimulus(0, 1, 8'h48, 32'h0, 8'h04, rd);
        checkOutput("rlr_second", rd, 32'h8000_0300);
        peek(8'h08, rd); checkOutput("rlr_R2_kept", rd, 32'h8000_0300);

        // Plain read of R has no side effect; simultaneous write+read on RLR
        applyStimulus(0, 1, 8'h14, 32'h0, 8'h07, rd);
        checkOutput("read_R5", rd, 32'h0);
        applyStimulus(1, 1, 8'h54, 32'h8000_0000, 8'h07, rd);
        checkOutput("wr_rd_data", rd, 32'h8000_0700);
        checkOutput("wr_rd_no_lock", {24'b0, sem_lock}, 32'h04);

        // Out-of-range semaphore index and undefined addresses
        applyStimulus(1, 0, 8'h20, 32'h8000_0001, 8'h01, rd);
        peek(8'h20, rd); checkOutput("oor_R8", rd, 32'h0);
        applyStimulus(0, 1, 8'h60, 32'h0, 8'h01, rd);
        checkOutput("oor_RLR8", rd, 32'h0);
        checkOutput("oor_lock", {24'b0, sem_lock}, 32'h04);
        peek(8'hA0, rd); checkOutput("undef_addr", rd, 32'h0);

        // Bulk clear by core 5
        applyStimulus(1, 0, 8'h04, 32'h8000_0011, 8'h05, rd);
        applyStimulus(1, 0, 8'h0C, 32'h8000_0022, 8'h05, rd);
        applyStimulus(1, 0, 8'h10, 32'h8000_0033, 8'h06, rd);
        checkOutput("pre_clear_lock", {24'b0, sem_lock}, 32'h1E);
        applyStimulus(1, 0, 8'h90, 32'h1234_0500, 8'h00, rd);
        checkOutput("bad_key_lock", {24'b0, sem_lock}, 32'h1E);
        peek(8'h88, rd); checkOutput("bad_key_isr", rd, 32'h0);
        applyStimulus(1, 0, 8'h90, 32'h5A5A_0500, 8'h00, rd);
        checkOutput("clear_lock", {24'b0, sem_lock}, 32'h14);
        peek(8'h88, rd); checkOutput("clear_isr", rd, 32'h0A);
        peek(8'h04, rd); checkOutput("clear_R1", rd, 32'h0);
        peek(8'h10, rd); checkOutput("clear_R4_kept", rd, 32'h8000_0633);
        peek(8'h90, rd); checkOutput("cr_reads0", rd, 32'h0);
        checkOutput("clear_irq_masked", {31'b0, sem_irq}, 32'h0);

        // Partial ICR clear and unmasking
        applyStimulus(1, 0, 8'h84, 32'h0000_0002, 8'h00, rd);
        peek(8'h88, rd); checkOutput("icr_partial", rd, 32'h08);
        applyStimulus(1, 0, 8'h80, 32'h0000_0008, 8'h00, rd);
        peek(8'h8C, rd); checkOutput("misr_bit3", rd, 32'h08);
        checkOutput("irq_unmasked", {31'b0, sem_irq}, 32'h1);

        // Reset during a lock access: the access is lost
        @(negedge hclk);
        hreset    = 1'b1;
        wr_en     = 1'b1;
        reg_addr  = 8'h18;
        ihwdata   = 32'h8000_0001;
        master_id = 8'h09;
        @(negedge hclk);
        hreset = 1'b0;
        wr_en  = 1'b0;
        checkOutput("rst_lock", {24'b0, sem_lock}, 32'h0);
        checkOutput("rst_irq", {31'b0, sem_irq}, 32'h0);
        peek(8'h18, rd); checkOutput("rst_R6", rd, 32'h0);
        peek(8'h08, rd); checkOutput("rst_R2", rd, 32'h0);
        peek(8'h80, rd); checkOutput("rst_IER", rd, 32'h0);
        peek(8'h88, rd); checkOutput("rst_ISR", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
